// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the iterative floating-point multiplier.
// Contents: FSM state enum, rounding-mode codes, operand class enum,
// a width-generic classify function and a canonical quiet-NaN builder.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_RND,
        ST_DONE
    } state_e;

    // Rounding-mode codes; 101..111 fall back to round-to-nearest-even
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } cls_e;

    // Widest field the helpers handle; callers zero-extend into it
    localparam int unsigned MAX_W = 64;

    // Classify a field pair; subnormals (exp == 0) are treated as zero
    function automatic cls_e classify(input logic [MAX_W-1:0] exp_f,
                                      input logic [MAX_W-1:0] frc_f,
                                      input int unsigned      exp_w);
        logic [MAX_W-1:0] ones;
        cls_e             cls;
        ones = (MAX_W'(1) << exp_w) - MAX_W'(1);
        if (exp_f == '0) begin
            cls = CLS_ZERO;
        end else if (exp_f == ones) begin
            cls = (frc_f == '0) ? CLS_INF : CLS_NAN;
        end else begin
            cls = CLS_NORM;
        end
        return cls;
    endfunction

    // Canonical qNaN: sign 0, exponent all-ones, fraction MSB set
    function automatic logic [MAX_W-1:0] canon_nan(input int unsigned exp_w,
                                                   input int unsigned frc_w);
        logic [MAX_W-1:0] r;
        r = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << frc_w;
        r = r | (MAX_W'(1) << (frc_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalise / round / pack stage.
// Ports: sign_i result sign, exp_sum_i biased exponent sum (eX+eY-BIAS,
// signed), prod_i raw significand product with two integer bits,
// r_mode_i rounding mode; z_c packed result plus ovrf/udrf/nx/zer/inf flags.
module fp_round_pack
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned FRC_W = 23
) (
    input  logic                      sign_i,
    input  logic signed [EXP_W+1:0]   exp_sum_i,
    input  logic [2*FRC_W+1:0]        prod_i,
    input  logic [2:0]                r_mode_i,
    output logic [EXP_W+FRC_W:0]      z_c,
    output logic                      ovrf_c,
    output logic                      udrf_c,
    output logic                      nx_c,
    output logic                      zer_c,
    output logic                      inf_c
);

    localparam int unsigned SIG_W = FRC_W + 1;
    localparam int unsigned PRD_W = 2 * SIG_W;
    localparam int unsigned EXS_W = EXP_W + 2;
    localparam int unsigned WORD_W = 1 + EXP_W + FRC_W;
    localparam int          E_MAX = (1 << EXP_W) - 1;

    logic                    norm_n;
    logic [SIG_W-1:0]        sig;
    logic                    guard;
    logic                    sticky;
    logic                    inc;
    logic [SIG_W:0]          sig_r;
    logic                    carry;
    logic [FRC_W-1:0]        frc_r;
    logic signed [EXS_W-1:0] e_z;
    logic                    to_inf;

    // Normalise, pick the round increment, then saturate the exponent
    always_comb begin
        norm_n = prod_i[PRD_W-1];
        if (norm_n) begin
            sig    = prod_i[PRD_W-1 -: SIG_W];
            guard  = prod_i[FRC_W];
            sticky = |prod_i[FRC_W-1:0];
        end else begin
            sig    = prod_i[PRD_W-2 -: SIG_W];
            guard  = prod_i[FRC_W-1];
            sticky = |prod_i[FRC_W-2:0];
        end

        case (r_mode_i)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign_i & (guard | sticky);
            RM_RUP:  inc = ~sign_i & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | sig[0]);
        endcase

        case (r_mode_i)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sign_i;
            RM_RUP:  to_inf = ~sign_i;
            default: to_inf = 1'b1;
        endcase

        // A carry out leaves 1.000..0, so the shifted-out LSB is always zero
        sig_r = {1'b0, sig} + (SIG_W+1)'(inc);
        carry = sig_r[SIG_W];
        frc_r = carry ? sig_r[FRC_W:1] : sig_r[FRC_W-1:0];
        e_z   = exp_sum_i + EXS_W'(norm_n) + EXS_W'(carry);

        z_c    = {sign_i, e_z[EXP_W-1:0], frc_r};
        ovrf_c = 1'b0;
        udrf_c = 1'b0;
        zer_c  = 1'b0;
        inf_c  = 1'b0;
        nx_c   = guard | sticky;

        if (int'(e_z) <= 0) begin
            z_c    = {sign_i, {(WORD_W-1){1'b0}}};
            udrf_c = 1'b1;
            zer_c  = 1'b1;
            nx_c   = 1'b1;
        end else if (int'(e_z) >= E_MAX) begin
            ovrf_c = 1'b1;
            nx_c   = 1'b1;
            if (to_inf) begin
                z_c   = {sign_i, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
                inf_c = 1'b1;
            end else begin
                z_c = {sign_i, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
            end
        end
    end

endmodule

// File: rtl/fp_mul_iter.sv
// Multi-cycle IEEE-754 multiplier: radix-4 Booth significand product,
// one round/pack cycle, valid/ready handshake on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with fp_X, fp_Y,
// r_mode; out_valid/out_ready with fp_Z and ovrf/udrf/nx/zer/inf/nan.
module fp_mul_iter
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned FRC_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+FRC_W:0] fp_X,
    input  logic [EXP_W+FRC_W:0] fp_Y,
    input  logic [2:0]           r_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+FRC_W:0] fp_Z,
    output logic                 ovrf,
    output logic                 udrf,
    output logic                 nx,
    output logic                 zer,
    output logic                 inf,
    output logic                 nan
);

    localparam int unsigned WORD_W = 1 + EXP_W + FRC_W;
    localparam int unsigned SIG_W  = FRC_W + 1;
    localparam int unsigned PRD_W  = 2 * SIG_W;
    localparam int unsigned EXS_W  = EXP_W + 2;
    localparam int unsigned ITER   = (FRC_W + 3) / 2;
    localparam int unsigned MPL_W  = 2 * ITER + 1;
    localparam int unsigned STEP_W = $clog2(ITER);
    localparam int unsigned BIAS   = (1 << (EXP_W - 1)) - 1;

    state_e                  state_q, state_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [PRD_W-1:0]        acc_q, acc_d;
    logic [PRD_W-1:0]        mcand_q, mcand_d;
    logic [MPL_W-1:0]        mplr_q, mplr_d;
    logic                    sign_q, sign_d;
    logic signed [EXS_W-1:0] exp_sum_q, exp_sum_d;
    logic [2:0]              rmode_q, rmode_d;
    logic [WORD_W-1:0]       z_q, z_d;
    logic                    ovrf_q, ovrf_d, udrf_q, udrf_d, nx_q, nx_d;
    logic                    zer_q, zer_d, inf_q, inf_d, nan_q, nan_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;

    cls_e                    cls_x, cls_y;
    logic [PRD_W-1:0]        pp;

    logic [WORD_W-1:0]       rp_z;
    logic                    rp_ovrf, rp_udrf, rp_nx, rp_zer, rp_inf;

    fp_round_pack #(
        .EXP_W (EXP_W),
        .FRC_W (FRC_W)
    ) u_round_pack (
        .sign_i    (sign_q),
        .exp_sum_i (exp_sum_q),
        .prod_i    (acc_q),
        .r_mode_i  (rmode_q),
        .z_c       (rp_z),
        .ovrf_c    (rp_ovrf),
        .udrf_c    (rp_udrf),
        .nx_c      (rp_nx),
        .zer_c     (rp_zer),
        .inf_c     (rp_inf)
    );

    // Operand classes seen at the input port (only used on accept)
    always_comb begin
        cls_x = classify(MAX_W'(fp_X[WORD_W-2 -: EXP_W]), MAX_W'(fp_X[FRC_W-1:0]), EXP_W);
        cls_y = classify(MAX_W'(fp_Y[WORD_W-2 -: EXP_W]), MAX_W'(fp_Y[FRC_W-1:0]), EXP_W);
    end

    // Booth partial product for the current digit; negatives wrap mod 2^PRD_W,
    // which is exact because the final product fits in PRD_W unsigned bits
    always_comb begin
        case (mplr_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        sign_d      = sign_q;
        exp_sum_d   = exp_sum_q;
        rmode_d     = rmode_q;
        z_d         = z_q;
        ovrf_d      = ovrf_q;
        udrf_d      = udrf_q;
        nx_d        = nx_q;
        zer_d       = zer_q;
        inf_d       = inf_q;
        nan_d       = nan_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d    = fp_X[WORD_W-1] ^ fp_Y[WORD_W-1];
                    rmode_d   = r_mode;
                    exp_sum_d = EXS_W'(fp_X[WORD_W-2 -: EXP_W]) + EXS_W'(fp_Y[WORD_W-2 -: EXP_W])
                              - EXS_W'(BIAS);
                    mcand_d   = PRD_W'({1'b1, fp_X[FRC_W-1:0]});
                    // Trailing 0 seeds the first Booth triplet; top zeros keep it unsigned
                    mplr_d    = MPL_W'({1'b1, fp_Y[FRC_W-1:0], 1'b0});
                    acc_d     = '0;
                    step_d    = '0;
                    z_d       = '0;
                    ovrf_d    = 1'b0;
                    udrf_d    = 1'b0;
                    nx_d      = 1'b0;
                    zer_d     = 1'b0;
                    inf_d     = 1'b0;
                    nan_d     = 1'b0;
                    if (cls_x == CLS_NAN || cls_y == CLS_NAN ||
                        (cls_x == CLS_INF && cls_y == CLS_ZERO) ||
                        (cls_x == CLS_ZERO && cls_y == CLS_INF)) begin
                        z_d     = WORD_W'(canon_nan(EXP_W, FRC_W));
                        nan_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (cls_x == CLS_INF || cls_y == CLS_INF) begin
                        z_d     = {fp_X[WORD_W-1] ^ fp_Y[WORD_W-1], {EXP_W{1'b1}}, {FRC_W{1'b0}}};
                        inf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (cls_x == CLS_ZERO || cls_y == CLS_ZERO) begin
                        z_d     = {fp_X[WORD_W-1] ^ fp_Y[WORD_W-1], {(WORD_W-1){1'b0}}};
                        zer_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                acc_d   = acc_q + pp;
                mcand_d = mcand_q << 2;
                mplr_d  = mplr_q >> 2;
                step_d  = step_q + STEP_W'(1);
                if (step_q == STEP_W'(ITER - 1)) begin
                    state_d = ST_RND;
                end
            end
            ST_RND: begin
                z_d     = rp_z;
                ovrf_d  = rp_ovrf;
                udrf_d  = rp_udrf;
                nx_d    = rp_nx;
                zer_d   = rp_zer;
                inf_d   = rp_inf;
                nan_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            sign_q      <= 1'b0;
            exp_sum_q   <= '0;
            rmode_q     <= '0;
            z_q         <= '0;
            ovrf_q      <= 1'b0;
            udrf_q      <= 1'b0;
            nx_q        <= 1'b0;
            zer_q       <= 1'b0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            sign_q      <= sign_d;
            exp_sum_q   <= exp_sum_d;
            rmode_q     <= rmode_d;
            z_q         <= z_d;
            ovrf_q      <= ovrf_d;
            udrf_q      <= udrf_d;
            nx_q        <= nx_d;
            zer_q       <= zer_d;
            inf_q       <= inf_d;
            nan_q       <= nan_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign fp_Z      = z_q;
    assign ovrf      = ovrf_q;
    assign udrf      = udrf_q;
    assign nx        = nx_q;
    assign zer       = zer_q;
    assign inf       = inf_q;
    assign nan       = nan_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter (binary32 configuration): directed vector table,
// hold / mid-operation reset sequences, and random operands checked
// against an arithmetic reference model.
module tb_fp_mul_iter;

    localparam int ITER = 13;
    localparam int NVEC = 18;
    localparam int NRND = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_X, fp_Y;
    logic [2:0]  r_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp_Z;
    logic        ovrf, udrf, nx, zer, inf, nan;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  m;
        logic [31:0] z;
        logic [5:0]  fl;   // {ovrf, udrf, nx, zer, inf, nan}
        int          lat;
    } vec_t;

    vec_t vt [NVEC];

    fp_mul_iter #(.EXP_W(8), .FRC_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .r_mode    (r_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf),
        .nx        (nx),
        .zer       (zer),
        .inf       (inf),
        .nan       (nan)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact integer product, rounding decided by comparing the
    // discarded remainder against one half ulp
    function automatic vec_t ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        vec_t r;
        int ex, ey, e, mm, sh;
        bit xz, xi, xn, yz, yi, yn, s, up, toinf;
        longint unsigned ma, mb, p, sig, rem, half;
        r.x = x; r.y = y; r.m = m; r.fl = '0; r.lat = 1; r.z = '0;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0); xi = (ex == 255) && (x[22:0] == 0); xn = (ex == 255) && (x[22:0] != 0);
        yz = (ey == 0); yi = (ey == 255) && (y[22:0] == 0); yn = (ey == 255) && (y[22:0] != 0);
        s  = x[31] ^ y[31];
        mm = (int'(m) > 4) ? 0 : int'(m);
        if (xn || yn || (xi && yz) || (xz && yi)) begin
            r.z = 32'h7FC00000; r.fl = 6'b000001;
        end else if (xi || yi) begin
            r.z = {s, 8'hFF, 23'h0}; r.fl = 6'b000010;
        end else if (xz || yz) begin
            r.z = {s, 31'h0}; r.fl = 6'b000100;
        end else begin
            r.lat = ITER + 2;
            ma = 64'({1'b1, x[22:0]});
            mb = 64'({1'b1, y[22:0]});
            p  = ma * mb;
            e  = ex + ey - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e++;
            end
            sig  = p >> sh;
            rem  = p - (sig << sh);
            half = 64'd1 << (sh - 1);
            case (mm)
                0:       up = (rem > half) || (rem == half && sig[0]);
                1:       up = 1'b0;
                2:       up = s && (rem != 0);
                3:       up = !s && (rem != 0);
                default: up = (rem >= half);
            endcase
            if (up) sig++;
            if (sig == (64'd1 << 24)) begin
                sig = 64'd1 << 23;
                e++;
            end
            if (e <= 0) begin
                r.z = {s, 31'h0}; r.fl = 6'b011100;
            end else if (e >= 255) begin
                toinf = (mm == 0) || (mm == 4) || (mm == 2 && s) || (mm == 3 && !s);
                if (toinf) begin
                    r.z = {s, 8'hFF, 23'h0}; r.fl = 6'b101010;
                end else begin
                    r.z = {s, 8'hFE, 23'h7FFFFF}; r.fl = 6'b101000;
                end
            end else begin
                r.z  = {s, e[7:0], sig[22:0]};
                r.fl = {2'b00, rem != 0, 3'b000};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        int          sel;
        logic [7:0]  e;
        sel = $urandom_range(0, 9);
        if (sel < 5)      e = 8'($urandom_range(100, 154));
        else if (sel < 7) e = 8'($urandom_range(190, 254));
        else if (sel < 8) e = 8'($urandom_range(1, 40));
        else              e = 8'($urandom_range(0, 255));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                            input bit early_rdy);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_wait: got 0 expected 1");
        end
        fp_X = x; fp_Y = y; r_mode = m; in_valid = 1'b1; out_ready = early_rdy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operand changes after the transfer must not matter
        fp_X = $urandom; fp_Y = $urandom; r_mode = 3'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 100);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string nm, input vec_t v, input bit early_rdy);
        int lat;
        start_op(v.x, v.y, v.m, early_rdy);
        wait_valid(lat);
        check({nm, ".z"}, fp_Z, v.z);
        check({nm, ".flags"}, 32'({ovrf, udrf, nx, zer, inf, nan}), 32'(v.fl));
        check({nm, ".lat"}, 32'(lat), 32'(v.lat));
        release_out();
    endtask

    initial begin
        int   lat;
        bit   seen;
        vec_t v;

        vt[0]  = '{32'h40400000, 32'h40400000, 3'd1, 32'h41100000, 6'b000000, 15};
        vt[1]  = '{32'h3FC00000, 32'h3FC00000, 3'd0, 32'h40100000, 6'b000000, 15};
        vt[2]  = '{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 6'b001000, 15};
        vt[3]  = '{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 6'b001000, 15};
        vt[4]  = '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 6'b001000, 15};
        vt[5]  = '{32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 6'b101010, 15};
        vt[6]  = '{32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 6'b101000, 15};
        vt[7]  = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 6'b000001, 1};
        vt[8]  = '{32'h00000001, 32'hC0000000, 3'd0, 32'h80000000, 6'b000100, 1};
        vt[9]  = '{32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 6'b011100, 15};
        vt[10] = '{32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 6'b101010, 15};
        vt[11] = '{32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 6'b101000, 15};
        vt[12] = '{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 6'b001000, 15};
        vt[13] = '{32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 6'b001000, 15};
        vt[14] = '{32'h3F800003, 32'h3FC00000, 3'd6, 32'h3FC00004, 6'b001000, 15};
        vt[15] = '{32'h7FC00001, 32'h3F800000, 3'd3, 32'h7FC00000, 6'b000001, 1};
        vt[16] = '{32'h7F800000, 32'hC0000000, 3'd1, 32'hFF800000, 6'b000010, 1};
        vt[17] = '{32'h3F800000, 32'hBF800000, 3'd2, 32'hBF800000, 6'b000000, 15};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        fp_X = '0; fp_Y = '0; r_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.fp_Z", fp_Z, 32'd0);
        check("reset.flags", 32'({ovrf, udrf, nx, zer, inf, nan}), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_check($sformatf("vec%0d", i), vt[i], 1'b0);
        end

        // Hold in DONE: outputs frozen, new requests ignored
        start_op(32'h3FC00000, 32'h3FC00000, 3'd0, 1'b0);
        wait_valid(lat);
        @(negedge clk);
        fp_X = 32'h40400000; fp_Y = 32'h40400000; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d.fp_Z", c), fp_Z, 32'h40100000);
            check($sformatf("hold%0d.in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("hold%0d.out_valid", c), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_out();
        check("post_release.in_ready", 32'(in_ready), 32'd1);
        check("post_release.out_valid", 32'(out_valid), 32'd0);

        // Reset while the Booth loop is at step 6
        start_op(32'h40400000, 32'h40400000, 3'd1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort.in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort.no_out_valid", 32'(seen), 32'd0);
        run_check("after_abort", vt[0], 1'b0);

        for (int i = 0; i < NRND; i++) begin
            v = ref_mul(rnd_op(), rnd_op(), 3'($urandom_range(0, 7)));
            run_check($sformatf("rnd%0d_%h_%h_m%0d", i, v.x, v.y, v.m), v, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
